mdu_seq: RTL

MDU_SEQ -- requirements
Module: mdu_seq

---
 rtl/mdu_seq.sv | 274 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/mdu_seq.sv
// Sequential multiply/divide unit for the RV64 M extension.
// Iterative shift-add multiply and restoring divide, one step per cycle.
package mdu_pkg;

  typedef enum logic [3:0] {
    MDU_NOP   = 4'd0,
    MDU_MUL   = 4'd1,
    MDU_DIV   = 4'd2,
    MDU_DIVU  = 4'd3,
    MDU_REM   = 4'd4,
    MDU_REMU  = 4'd5,
    MDU_MULW  = 4'd6,
    MDU_DIVW  = 4'd7,
    MDU_DIVUW = 4'd8,
    MDU_REMW  = 4'd9,
    MDU_REMUW = 4'd10
  } mdu_op_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } mdu_state_t;

endpackage

module mdu_seq (
  input  logic        clk,
  input  logic        reset,
  input  logic        flush,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [3:0]  op,
  input  logic [63:0] srca,
  input  logic [63:0] srcb,
  input  logic [4:0]  dst,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] result,
  output logic [4:0]  out_dst,
  output logic        busy
);

  import mdu_pkg::*;

  function automatic logic [63:0] sext32(
    input logic [31:0] v
  );
    return {{32{v[31]}}, v};
  endfunction

  mdu_state_t  state_q, state_d;
  logic        accept;

  // incoming request decode
  logic        d_w, d_mul, d_div, d_rem, d_sgn;
  logic        sa, sb, dz, ovf, d_special;
  logic [63:0] opa, opb, mag_a, mag_b;
  logic [63:0] d_spec_res;

  // datapath state
  logic [63:0] a_q, a_d;
  logic [63:0] b_q, b_d;
  logic [63:0] acc_q, acc_d;
  logic [5:0]  cnt_q, cnt_d;
  logic        w_q, w_d;
  logic        mul_q, mul_d;
  logic        rem_q, rem_d;
  logic        qneg_q, qneg_d;
  logic        rneg_q, rneg_d;
  logic [63:0] res_q, res_d;
  logic [4:0]  dst_q, dst_d;

  // one iteration step and completion value
  logic [63:0] prod;
  logic [64:0] rsh, diff;
  logic        ge;
  logic [63:0] step_a, step_b, step_acc;
  logic        last;
  logic [63:0] q, qv, rv, val, fin;

  // decode op, form operands, detect single-cycle cases
  always_comb begin
    d_w   = 1'b0;
    d_mul = 1'b0;
    d_div = 1'b0;
    d_rem = 1'b0;
    d_sgn = 1'b0;
    case (op)
      MDU_MUL:   d_mul = 1'b1;
      MDU_MULW: begin
        d_mul = 1'b1;
        d_w   = 1'b1;
      end
      MDU_DIV: begin
        d_div = 1'b1;
        d_sgn = 1'b1;
      end
      MDU_DIVU:  d_div = 1'b1;
      MDU_REM: begin
        d_rem = 1'b1;
        d_sgn = 1'b1;
      end
      MDU_REMU:  d_rem = 1'b1;
      MDU_DIVW: begin
        d_div = 1'b1;
        d_sgn = 1'b1;
        d_w   = 1'b1;
      end
      MDU_DIVUW: begin
        d_div = 1'b1;
        d_w   = 1'b1;
      end
      MDU_REMW: begin
        d_rem = 1'b1;
        d_sgn = 1'b1;
        d_w   = 1'b1;
      end
      MDU_REMUW: begin
        d_rem = 1'b1;
        d_w   = 1'b1;
      end
      default: ;
    endcase
    sa  = d_w ? srca[31] : srca[63];
    sb  = d_w ? srcb[31] : srcb[63];
    opa = d_w ? {{32{d_sgn & srca[31]}}, srca[31:0]}
              : srca;
    opb = d_w ? {{32{d_sgn & srcb[31]}}, srcb[31:0]}
              : srcb;
    mag_a = (d_sgn & sa) ? -opa : opa;
    mag_b = (d_sgn & sb) ? -opb : opb;
    dz  = (d_div | d_rem) && (opb == 64'd0);
    ovf = d_sgn && (opb == '1) &&
          (opa == (d_w ? 64'hFFFF_FFFF_8000_0000
                       : 64'h8000_0000_0000_0000));
    d_special = !d_mul && (!(d_div | d_rem) || dz || ovf);
    d_spec_res = 64'd0;
    if (dz)
      d_spec_res = d_div ? '1
                 : (d_w ? sext32(srca[31:0]) : srca);
    else if (ovf)
      d_spec_res = d_div ? opa : 64'd0;
  end

  // one shift-add or restoring-divide step
  always_comb begin
    prod = acc_q + (b_q[0] ? a_q : 64'd0);
    rsh  = {acc_q, a_q[63]};
    diff = rsh - {1'b0, b_q};
    ge   = ~diff[64];
    if (mul_q) begin
      step_acc = prod;
      step_a   = a_q << 1;
      step_b   = b_q >> 1;
    end else begin
      step_acc = ge ? diff[63:0] : rsh[63:0];
      step_a   = {a_q[62:0], ge};
      step_b   = b_q;
    end
    last = cnt_q == (w_q ? 6'd31 : 6'd63);
    q    = w_q ? {32'd0, step_a[31:0]} : step_a;
    qv   = qneg_q ? -q : q;
    rv   = rneg_q ? -step_acc : step_acc;
    val  = mul_q ? step_acc : (rem_q ? rv : qv);
    fin  = w_q ? sext32(val[31:0]) : val;
  end

  // state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // next state; flush overrides everything
  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE:
          if (in_valid)
            state_d = d_special ? S_DONE : S_CALC;
        S_CALC:
          if (last) state_d = S_DONE;
        S_DONE:
          if (out_ready) state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // handshake and status outputs
  always_comb begin
    in_ready  = state_q == S_IDLE;
    out_valid = state_q == S_DONE;
    busy      = (state_q == S_CALC) ||
                (state_q == S_DONE);
    accept    = in_valid && (state_q == S_IDLE) &&
                !flush;
    result    = res_q;
    out_dst   = dst_q;
  end

  // datapath next values: load on accept, step in CALC
  always_comb begin
    a_d    = a_q;
    b_d    = b_q;
    acc_d  = acc_q;
    cnt_d  = cnt_q;
    w_d    = w_q;
    mul_d  = mul_q;
    rem_d  = rem_q;
    qneg_d = qneg_q;
    rneg_d = rneg_q;
    res_d  = res_q;
    dst_d  = dst_q;
    if (accept) begin
      cnt_d  = 6'd0;
      acc_d  = 64'd0;
      dst_d  = dst;
      w_d    = d_w;
      mul_d  = d_mul;
      rem_d  = d_rem;
      qneg_d = d_sgn & (sa ^ sb);
      rneg_d = d_sgn & sa;
      if (d_mul) begin
        a_d = opa;
        b_d = opb;
      end else begin
        a_d = d_w ? {mag_a[31:0], 32'd0} : mag_a;
        b_d = mag_b;
      end
      if (d_special) res_d = d_spec_res;
    end else if (state_q == S_CALC && !flush) begin
      a_d   = step_a;
      b_d   = step_b;
      acc_d = step_acc;
      cnt_d = cnt_q + 6'd1;
      if (last) res_d = fin;
    end
  end

  // datapath registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      a_q    <= 64'd0;
      b_q    <= 64'd0;
      acc_q  <= 64'd0;
      cnt_q  <= 6'd0;
      w_q    <= 1'b0;
      mul_q  <= 1'b0;
      rem_q  <= 1'b0;
      qneg_q <= 1'b0;
      rneg_q <= 1'b0;
      res_q  <= 64'd0;
      dst_q  <= 5'd0;
    end else begin
      a_q    <= a_d;
      b_q    <= b_d;
      acc_q  <= acc_d;
      cnt_q  <= cnt_d;
      w_q    <= w_d;
      mul_q  <= mul_d;
      rem_q  <= rem_d;
      qneg_q <= qneg_d;
      rneg_q <= rneg_d;
      res_q  <= res_d;
      dst_q  <= dst_d;
    end
  end

endmodule
